// File: rtl/battle_pkg.sv
// Shared types and constants for the battle turn scheduler.
package battle_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ATK1,
    ST_CHK1,
    ST_ATK2,
    ST_CHK2,
    ST_VICTORY,
    ST_LOSS,
    ST_FAULT
  } state_t;

  localparam logic ATTACKER_PLAYER = 1'b0;
  localparam logic ATTACKER_AI     = 1'b1;
  localparam logic TARGET_PLAYER   = 1'b0;
  localparam logic TARGET_AI       = 1'b1;

  localparam int unsigned MOVE_W = 2;
  localparam int unsigned TURN_W = 8;
  localparam int unsigned LFSR_W = 8;

  typedef logic [MOVE_W-1:0] move_idx_t;

endpackage

// File: rtl/battle_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left.
module battle_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] value
);

  logic feedback;

  // Feedback taps at stages 8, 6, 5 and 4.
  always_comb begin
    feedback = value[7] ^ value[5] ^ value[4] ^ value[3];
  end

  // Shift register; reloads the seed on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (enable) begin
      value <= {value[6:0], feedback};
    end
  end

endmodule

// File: rtl/battle_turn_scheduler.sv
// Sequences one battle turn: move select, speed ordering, two attacks with
// req/ack to the damage datapath, defeat checks and an ack watchdog.
module battle_turn_scheduler
  import battle_pkg::*;
#(
  parameter int unsigned SPEED_W     = 8,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [1:0]         p_move,
  input  logic [SPEED_W-1:0] p_speed,
  input  logic [SPEED_W-1:0] ai_speed,
  input  logic               p_dead,
  input  logic               ai_dead,
  input  logic               dmg_ack,
  output logic               dmg_req,
  output logic               attacker,
  output logic               target,
  output logic [1:0]         move_idx,
  output logic [1:0]         ai_move,
  output logic [7:0]         turn_count,
  output logic               busy,
  output logic               victory,
  output logic               loss,
  output logic               fault
);

  localparam int unsigned WD_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  state_t            state, state_d;
  logic              go_q;
  logic              tie_bit, tie_d;
  logic              first_ai, first_d;
  move_idx_t         p_move_q, p_move_d;
  move_idx_t         ai_move_d;
  logic [TURN_W-1:0] turn_d;
  logic [WD_W-1:0]   wd_cnt, wd_d;
  logic [LFSR_W-1:0] lfsr_value;

  logic              dmg_req_d, attacker_d, target_d, busy_d;
  logic              victory_d, loss_d, fault_d;
  move_idx_t         move_idx_d;

  battle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .value  (lfsr_value)
  );

  // Next-state, turn bookkeeping and registered-output decode.
  always_comb begin
    state_d    = state;
    tie_d      = tie_bit;
    first_d    = first_ai;
    p_move_d   = p_move_q;
    ai_move_d  = ai_move;
    turn_d     = turn_count;
    wd_d       = wd_cnt;
    attacker_d = attacker;
    target_d   = target;
    move_idx_d = move_idx;

    unique case (state)
      ST_IDLE: begin
        if (go && !go_q) begin
          state_d  = ST_SELECT;
          p_move_d = p_move;
        end
      end
      ST_SELECT: begin
        ai_move_d = lfsr_value[1:0];
        if (p_speed > ai_speed) begin
          first_d = ATTACKER_PLAYER;
        end else if (p_speed < ai_speed) begin
          first_d = ATTACKER_AI;
        end else begin
          first_d = tie_bit;
          tie_d   = ~tie_bit;
        end
        wd_d    = '0;
        state_d = ST_ATK1;
      end
      ST_ATK1, ST_ATK2: begin
        if (dmg_ack) begin
          state_d = (state == ST_ATK1) ? ST_CHK1 : ST_CHK2;
        end else if (wd_cnt == WD_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
        end else begin
          wd_d = wd_cnt + WD_W'(1);
        end
      end
      ST_CHK1, ST_CHK2: begin
        if (ai_dead) begin
          state_d = ST_VICTORY;
        end else if (p_dead) begin
          state_d = ST_LOSS;
        end else if (state == ST_CHK1) begin
          wd_d    = '0;
          state_d = ST_ATK2;
        end else begin
          state_d = ST_IDLE;
          if (turn_count != '1) begin
            turn_d = turn_count + TURN_W'(1);
          end
        end
      end
      default: begin
        state_d = state;
      end
    endcase

    dmg_req_d = (state_d == ST_ATK1) || (state_d == ST_ATK2);
    busy_d    = state_d inside {ST_SELECT, ST_ATK1, ST_CHK1, ST_ATK2, ST_CHK2};
    victory_d = (state_d == ST_VICTORY);
    loss_d    = (state_d == ST_LOSS);
    fault_d   = (state_d == ST_FAULT);

    if (dmg_req_d) begin
      attacker_d = (state_d == ST_ATK1) ? first_d : ~first_d;
      target_d   = (attacker_d == ATTACKER_AI) ? TARGET_PLAYER : TARGET_AI;
      move_idx_d = (attacker_d == ATTACKER_AI) ? ai_move_d : p_move_d;
    end
  end

  // State, turn context and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      go_q       <= 1'b0;
      tie_bit    <= 1'b0;
      first_ai   <= ATTACKER_PLAYER;
      p_move_q   <= '0;
      ai_move    <= '0;
      turn_count <= '0;
      wd_cnt     <= '0;
      dmg_req    <= 1'b0;
      attacker   <= ATTACKER_PLAYER;
      target     <= TARGET_PLAYER;
      move_idx   <= '0;
      busy       <= 1'b0;
      victory    <= 1'b0;
      loss       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      go_q       <= go;
      tie_bit    <= tie_d;
      first_ai   <= first_d;
      p_move_q   <= p_move_d;
      ai_move    <= ai_move_d;
      turn_count <= turn_d;
      wd_cnt     <= wd_d;
      dmg_req    <= dmg_req_d;
      attacker   <= attacker_d;
      target     <= target_d;
      move_idx   <= move_idx_d;
      busy       <= busy_d;
      victory    <= victory_d;
      loss       <= loss_d;
      fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_battle_turn_scheduler.sv
// Self-checking bench for battle_turn_scheduler with a turn-level reference model.
module tb_battle_turn_scheduler;

  localparam int unsigned SPEED_W     = 8;
  localparam int unsigned ACK_TIMEOUT = 15;
  localparam logic [7:0]  SEED        = 8'hA5;

  logic               clk = 1'b0;
  logic               reset;
  logic               go;
  logic [1:0]         p_move;
  logic [SPEED_W-1:0] p_speed;
  logic [SPEED_W-1:0] ai_speed;
  logic               p_dead;
  logic               ai_dead;
  logic               dmg_ack;
  logic               dmg_req;
  logic               attacker;
  logic               target;
  logic [1:0]         move_idx;
  logic [1:0]         ai_move;
  logic [7:0]         turn_count;
  logic               busy;
  logic               victory;
  logic               loss;
  logic               fault;

  int checks = 0;
  int errors = 0;

  // Reference state: free-running random source, tie alternation, completed turns.
  logic [7:0] m_lfsr;
  logic       m_tie;
  int         exp_turns;

  always #5 clk = ~clk;

  battle_turn_scheduler #(
    .SPEED_W     (SPEED_W),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .p_move     (p_move),
    .p_speed    (p_speed),
    .ai_speed   (ai_speed),
    .p_dead     (p_dead),
    .ai_dead    (ai_dead),
    .dmg_ack    (dmg_ack),
    .dmg_req    (dmg_req),
    .attacker   (attacker),
    .target     (target),
    .move_idx   (move_idx),
    .ai_move    (ai_move),
    .turn_count (turn_count),
    .busy       (busy),
    .victory    (victory),
    .loss       (loss),
    .fault      (fault)
  );

  // Polynomial x^8+x^6+x^5+x^4+1: feedback is the parity of tap mask 0xB8.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; go = 1'b0; dmg_ack = 1'b0; p_dead = 1'b0; ai_dead = 1'b0;
    m_tie = 1'b0; exp_turns = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One turn; res: 0 = continues, 1 = victory, 2 = loss. ai_at/p_at = which ack raises a dead flag.
  task automatic do_turn(input logic [7:0] ps, input logic [7:0] as, input logic [1:0] pm,
                         input int ai_at, input int p_at, input bit hold_go, output int res);
    logic       exp_first, exp_att;
    logic [1:0] exp_ai, exp_mv;
    res = 0;
    if (ps > as)      exp_first = 1'b0;
    else if (ps < as) exp_first = 1'b1;
    else begin
      exp_first = m_tie;
      m_tie = ~m_tie;
    end
    @(negedge clk);
    p_speed = ps; ai_speed = as; p_move = pm; go = 1'b1;
    @(posedge clk);
    #1 exp_ai = m_lfsr[1:0];
    @(negedge clk);
    if (!hold_go) go = 1'b0;
    checks++;
    if (dmg_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL select: dmg_req=%b busy=%b, want 0 1", dmg_req, busy);
    end
    @(negedge clk);
    for (int i = 1; i <= 2; i++) begin
      exp_att = (i == 1) ? exp_first : ~exp_first;
      exp_mv  = exp_att ? exp_ai : pm;
      checks++;
      if (dmg_req !== 1'b1 || attacker !== exp_att || target !== ~exp_att ||
          move_idx !== exp_mv || ai_move !== exp_ai) begin
        errors++;
        $display("FAIL req%0d: req=%b att=%b tgt=%b mv=%0d ai=%0d, want 1 %b %b %0d %0d",
                 i, dmg_req, attacker, target, move_idx, ai_move, exp_att, ~exp_att, exp_mv, exp_ai);
      end
      dmg_ack = 1'b1;
      if (ai_at == i) ai_dead = 1'b1;
      if (p_at == i)  p_dead = 1'b1;
      @(negedge clk);
      dmg_ack = 1'b0;
      checks++;
      if (dmg_req !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL chk%0d: dmg_req=%b busy=%b, want 0 1", i, dmg_req, busy);
      end
      @(negedge clk);
      if (ai_dead) begin
        checks++;
        if (victory !== 1'b1 || loss !== 1'b0 || busy !== 1'b0 || dmg_req !== 1'b0) begin
          errors++;
          $display("FAIL victory: v=%b l=%b busy=%b req=%b, want 1 0 0 0", victory, loss, busy, dmg_req);
        end
        res = 1;
        return;
      end else if (p_dead) begin
        checks++;
        if (loss !== 1'b1 || victory !== 1'b0 || busy !== 1'b0 || dmg_req !== 1'b0) begin
          errors++;
          $display("FAIL loss: l=%b v=%b busy=%b req=%b, want 1 0 0 0", loss, victory, busy, dmg_req);
        end
        res = 2;
        return;
      end else if (i == 2) begin
        if (exp_turns < 255) exp_turns++;
        checks++;
        if (busy !== 1'b0 || turn_count !== 8'(exp_turns)) begin
          errors++;
          $display("FAIL turn_end: busy=%b turns=%0d, want 0 %0d", busy, turn_count, exp_turns);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({dmg_req, attacker, target, move_idx, ai_move, turn_count, busy, victory, loss, fault} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {dmg_req, attacker, target, move_idx, ai_move, turn_count, busy, victory, loss, fault});
    end
    checks++;
    if (dut.u_lfsr.value !== SEED) begin
      errors++;
      $display("FAIL reset_lfsr: got %h, want %h", dut.u_lfsr.value, SEED);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    int res;
    apply_reset();
    do_turn(8'd50, 8'd30, 2'd2, 0, 0, 1'b0, res);
    do_turn(8'd50, 8'd30, 2'd1, 0, 0, 1'b0, res);
  endtask

  task automatic test_ai_first_loss();
    int res;
    apply_reset();
    do_turn(8'd20, 8'd90, 2'd3, 0, 1, 1'b0, res);
    repeat (3) @(negedge clk);
    checks++;
    if (res != 2 || dmg_req !== 1'b0 || loss !== 1'b1) begin
      errors++;
      $display("FAIL loss_hold: res=%0d req=%b loss=%b, want 2 0 1", res, dmg_req, loss);
    end
  endtask

  task automatic test_tie();
    int res;
    apply_reset();
    for (int t = 0; t < 3; t++) do_turn(8'd40, 8'd40, 2'(t), 0, 0, 1'b0, res);
  endtask

  task automatic test_victory_priority();
    int res;
    apply_reset();
    do_turn(8'd50, 8'd30, 2'd0, 1, 1, 1'b0, res);
    checks++;
    if (res != 1) begin
      errors++;
      $display("FAIL victory_prio: outcome=%0d, want 1", res);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    @(negedge clk);
    p_speed = 8'd50; ai_speed = 8'd30; p_move = 2'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    checks++;
    if (dmg_req !== 1'b1) begin
      errors++;
      $display("FAIL to_req: dmg_req=%b, want 1", dmg_req);
    end
    repeat (ACK_TIMEOUT - 1) @(negedge clk);
    checks++;
    if (fault !== 1'b0 || dmg_req !== 1'b1) begin
      errors++;
      $display("FAIL to_early: fault=%b req=%b, want 0 1", fault, dmg_req);
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || dmg_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_fault: fault=%b req=%b busy=%b, want 1 0 0", fault, dmg_req, busy);
    end
  endtask

  task automatic test_go_held();
    int res;
    apply_reset();
    do_turn(8'd30, 8'd60, 2'd2, 0, 0, 1'b1, res);
    for (int c = 0; c < 12; c++) begin
      if (c == 3) dmg_ack = 1'b1;
      @(negedge clk);
      dmg_ack = 1'b0;
      checks++;
      if (busy !== 1'b0 || dmg_req !== 1'b0 || turn_count !== 8'd1) begin
        errors++;
        $display("FAIL go_held: busy=%b req=%b turns=%0d, want 0 0 1", busy, dmg_req, turn_count);
      end
    end
    go = 1'b0;
    do_turn(8'd30, 8'd60, 2'd0, 0, 0, 1'b0, res);
  endtask

  task automatic test_preset_dead();
    int res;
    apply_reset();
    p_dead = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || loss !== 1'b0) begin
      errors++;
      $display("FAIL idle_dead: busy=%b loss=%b, want 0 0", busy, loss);
    end
    do_turn(8'd70, 8'd10, 2'd1, 0, 0, 1'b0, res);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    p_speed = 8'd50; ai_speed = 8'd30; p_move = 2'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    dmg_ack = 1'b1;
    @(negedge clk);
    dmg_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (dmg_req !== 1'b1 || attacker !== 1'b1) begin
      errors++;
      $display("FAIL mid_atk2: req=%b att=%b, want 1 1", dmg_req, attacker);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dmg_req, attacker, target, move_idx, ai_move, turn_count, busy, victory, loss, fault} !== 18'd0
        || dut.u_lfsr.value !== SEED) begin
      errors++;
      $display("FAIL mid_reset: outs=%b lfsr=%h, want zero %h",
               {dmg_req, attacker, target, move_idx, ai_move, turn_count, busy, victory, loss, fault},
               dut.u_lfsr.value, SEED);
    end
    apply_reset();
  endtask

  task automatic test_saturate();
    int res;
    apply_reset();
    for (int t = 0; t < 257; t++) begin
      do_turn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
              0, 0, 1'b0, res);
    end
    checks++;
    if (turn_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate: turns=%0d, want 255", turn_count);
    end
  endtask

  task automatic test_random();
    int res, ai_at, p_at;
    apply_reset();
    for (int t = 0; t < 60; t++) begin
      ai_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      p_at  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_turn(8'($urandom_range(10, 13)), 8'($urandom_range(10, 13)), 2'($urandom_range(0, 3)),
              ai_at, p_at, 1'b0, res);
      if (res != 0) apply_reset();
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; p_move = 2'd0; p_speed = '0; ai_speed = '0;
    p_dead = 1'b0; ai_dead = 1'b0; dmg_ack = 1'b0;
    m_tie = 1'b0; exp_turns = 0;
    test_reset();
    test_basic();
    test_ai_first_loss();
    test_tie();
    test_victory_priority();
    test_timeout();
    test_go_held();
    test_preset_dead();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
